// File: rtl/display_scheduler.sv
// display_scheduler: chooses what the 4-digit seven-segment driver shows.
// It shows the live score during play. After game over it alternates between
// the final score and the high score. A timed alert value pre-empts both.
// Each value is held for a whole slot and clamped to 0..9999.
module display_scheduler #(
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int ALERT_CYCLES = 200_000_000,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] score,
   input  logic [15:0] hiscore,
   input  logic        game_over,
   input  logic        alert_req,
   input  logic [15:0] alert_value,
   output logic [15:0] disp_value,
   output logic        disp_blank,
   output logic [1:0]  disp_src,
   output logic        slot_start
);

   localparam int MAXP_DA = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
   localparam int MAXP    = (MAXP_DA > BLINK_CYCLES) ? MAXP_DA : BLINK_CYCLES;
   localparam int CW      = (MAXP > 1) ? $clog2(MAXP) : 1;

   localparam logic [CW-1:0] DWELL_TC = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] ALERT_TC = CW'(ALERT_CYCLES - 1);
   localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      PLAY     = 2'd0,
      GO_SCORE = 2'd1,
      GO_HI    = 2'd2,
      ALERT    = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] dwell_r, dwell_s;
   logic [CW-1:0] alert_r, alert_s;
   logic [CW-1:0] blink_r, blink_s;
   logic [15:0]   s_val_r, s_val_s;
   logic [15:0]   h_val_r, h_val_s;
   logic [15:0]   a_val_r, a_val_s;
   logic          record_r, record_s;
   logic [15:0]   value_s;
   logic          blank_s;
   logic [1:0]    src_s;
   logic          slot_s;
   logic          go_alert_s, go_score_s, go_hi_s, go_play_s;

   // Limit a binary value to what four decimal digits can show
   function automatic logic [15:0] clamp(input logic [15:0] x);
      return (x > 16'd9999) ? 16'd9999 : x;
   endfunction

   // Next-state selection followed by next-output and counter computation
   always_comb begin
      state_s    = state_r;
      dwell_s    = dwell_r;
      alert_s    = alert_r;
      blink_s    = blink_r;
      s_val_s    = s_val_r;
      h_val_s    = h_val_r;
      a_val_s    = a_val_r;
      record_s   = record_r;
      value_s    = disp_value;
      blank_s    = 1'b0;
      src_s      = disp_src;
      slot_s     = 1'b0;
      go_alert_s = 1'b0;
      go_score_s = 1'b0;
      go_hi_s    = 1'b0;
      go_play_s  = 1'b0;

      // Event priority: alert request, then game_over change, then terminal count
      case (state_r)
         PLAY: begin
            if (alert_req)      go_alert_s = 1'b1;
            else if (game_over) go_score_s = 1'b1;
            else                go_play_s  = 1'b0;
         end
         GO_SCORE: begin
            if (alert_req)                go_alert_s = 1'b1;
            else if (!game_over)          go_play_s  = 1'b1;
            else if (dwell_r == DWELL_TC) go_hi_s    = 1'b1;
            else                          go_hi_s    = 1'b0;
         end
         GO_HI: begin
            if (alert_req)                go_alert_s = 1'b1;
            else if (!game_over)          go_play_s  = 1'b1;
            else if (dwell_r == DWELL_TC) go_score_s = 1'b1;
            else                          go_score_s = 1'b0;
         end
         ALERT: begin
            if (alert_req) go_alert_s = 1'b1;
            else if (alert_r == ALERT_TC) begin
               if (game_over) go_score_s = 1'b1;
               else           go_play_s  = 1'b1;
            end else go_play_s = 1'b0;
         end
         default: go_play_s = 1'b1;
      endcase

      if (go_alert_s) begin
         state_s = ALERT;
         a_val_s = clamp(alert_value);
         value_s = clamp(alert_value);
         src_s   = 2'd2;
         slot_s  = 1'b1;
         dwell_s = CNT_ZERO;
         alert_s = CNT_ZERO;
         blink_s = CNT_ZERO;
      end else if (go_score_s) begin
         // The score / high-score pair is captured once per GO_SCORE entry
         state_s  = GO_SCORE;
         s_val_s  = clamp(score);
         h_val_s  = clamp(hiscore);
         record_s = (clamp(score) >= clamp(hiscore));
         value_s  = clamp(score);
         src_s    = 2'd0;
         slot_s   = 1'b1;
         dwell_s  = CNT_ZERO;
         alert_s  = CNT_ZERO;
         blink_s  = CNT_ZERO;
      end else if (go_hi_s) begin
         state_s = GO_HI;
         value_s = h_val_r;
         src_s   = 2'd1;
         slot_s  = 1'b1;
         dwell_s = CNT_ZERO;
         blink_s = CNT_ZERO;
      end else if (go_play_s) begin
         state_s = PLAY;
         value_s = clamp(score);
         src_s   = 2'd0;
         slot_s  = 1'b1;
         dwell_s = CNT_ZERO;
         alert_s = CNT_ZERO;
         blink_s = CNT_ZERO;
      end else begin
         case (state_r)
            PLAY:     value_s = clamp(score);
            GO_SCORE: dwell_s = dwell_r + CNT_ONE;
            GO_HI: begin
               dwell_s = dwell_r + CNT_ONE;
               if (blink_r == BLINK_TC) begin
                  blink_s = CNT_ZERO;
                  blank_s = record_r ? ~disp_blank : 1'b0;
               end else begin
                  blink_s = blink_r + CNT_ONE;
                  blank_s = disp_blank;
               end
            end
            ALERT:    alert_s = alert_r + CNT_ONE;
            default:  value_s = disp_value;
         endcase
      end
   end

   // State, counters, latched values and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= PLAY;
         dwell_r    <= CNT_ZERO;
         alert_r    <= CNT_ZERO;
         blink_r    <= CNT_ZERO;
         s_val_r    <= 16'd0;
         h_val_r    <= 16'd0;
         a_val_r    <= 16'd0;
         record_r   <= 1'b0;
         disp_value <= 16'd0;
         disp_blank <= 1'b0;
         disp_src   <= 2'd0;
         slot_start <= 1'b0;
      end else begin
         state_r    <= state_s;
         dwell_r    <= dwell_s;
         alert_r    <= alert_s;
         blink_r    <= blink_s;
         s_val_r    <= s_val_s;
         h_val_r    <= h_val_s;
         a_val_r    <= a_val_s;
         record_r   <= record_s;
         disp_value <= value_s;
         disp_blank <= blank_s;
         disp_src   <= src_s;
         slot_start <= slot_s;
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with a slot-level reference model.
module tb_display_scheduler;

   localparam int DW = 8;
   localparam int AL = 5;
   localparam int BL = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] score, hiscore, alert_value;
   logic        game_over, alert_req;
   logic [15:0] disp_value;
   logic        disp_blank;
   logic [1:0]  disp_src;
   logic        slot_start;

   int checks = 0;
   int failures = 0;

   // Reference model: mode 0 play, 1 final score, 2 high score, 3 alert
   int m_mode, m_elapsed, m_s, m_h, m_a;
   logic [15:0] e_val;
   logic        e_blank, e_slot;
   logic [1:0]  e_src;

   display_scheduler #(.DWELL_CYCLES(DW), .ALERT_CYCLES(AL), .BLINK_CYCLES(BL)) dut (
      .clk(clk), .rst_n(rst_n), .score(score), .hiscore(hiscore),
      .game_over(game_over), .alert_req(alert_req), .alert_value(alert_value),
      .disp_value(disp_value), .disp_blank(disp_blank), .disp_src(disp_src),
      .slot_start(slot_start)
   );

   always #5 clk = ~clk;

   function automatic int clampm(input int x);
      return (x > 9999) ? 9999 : x;
   endfunction

   // Advance the model by one edge using the inputs the DUT is about to sample
   task automatic model_step();
      int nm;
      bit restart;
      if (!rst_n) begin
         m_mode = 0; m_elapsed = 0; m_s = 0; m_h = 0; m_a = 0;
         e_val = 16'd0; e_blank = 1'b0; e_src = 2'd0; e_slot = 1'b0;
         return;
      end
      nm = m_mode;
      restart = 1'b0;
      if (alert_req) begin
         nm = 3; restart = 1'b1; m_a = clampm(int'(alert_value));
      end else begin
         case (m_mode)
            0: if (game_over) begin nm = 1; restart = 1'b1; end
            1, 2: begin
               if (!game_over) begin nm = 0; restart = 1'b1; end
               else if (m_elapsed + 1 == DW) begin nm = 3 - m_mode; restart = 1'b1; end
            end
            default: if (m_elapsed + 1 == AL) begin nm = game_over ? 1 : 0; restart = 1'b1; end
         endcase
      end
      if (restart) begin
         m_elapsed = 0;
         if (nm == 1) begin
            m_s = clampm(int'(score));
            m_h = clampm(int'(hiscore));
         end
      end else begin
         m_elapsed++;
      end
      e_slot = restart;
      m_mode = nm;
      case (m_mode)
         0: begin e_src = 2'd0; e_val = 16'(clampm(int'(score))); end
         1: begin e_src = 2'd0; e_val = 16'(m_s); end
         2: begin e_src = 2'd1; e_val = 16'(m_h); end
         default: begin e_src = 2'd2; e_val = 16'(m_a); end
      endcase
      e_blank = (m_mode == 2 && m_s >= m_h) ? (((m_elapsed / BL) % 2) == 1) : 1'b0;
   endtask

   // One clock: update model, pass the edge, settle before sampling
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; score = 16'd1234;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {16'd0, 1'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got val=%0d blank=%0b src=%0d slot=%0b want 0/0/0/0",
                     disp_value, disp_blank, disp_src, slot_start);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (disp_value !== 16'd1234 || slot_start !== 1'b0) begin
         failures++;
         $display("FAIL play_after_reset got val=%0d slot=%0b want 1234 slot=0", disp_value, slot_start);
      end
      score = 16'd12000;
      tick();
      checks++;
      if (disp_value !== 16'd9999 || disp_src !== 2'd0) begin
         failures++;
         $display("FAIL play_clamp got val=%0d src=%0d want 9999 src=0", disp_value, disp_src);
      end
   endtask

   task automatic test_game_over_no_record();
      int pulses = 0;
      score = 16'd50; hiscore = 16'd900; game_over = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i == 4) score = 16'd60;
         tick();
         if (slot_start) pulses++;
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {e_val, e_blank, e_src, e_slot}) begin
            failures++;
            $display("FAIL gameover_cycle%0d got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i,
                     disp_value, disp_blank, disp_src, slot_start, e_val, e_blank, e_src, e_slot);
         end
      end
      checks++;
      if (disp_value !== 16'd60 || pulses != 3) begin
         failures++;
         $display("FAIL gameover_relatch got val=%0d pulses=%0d want 60 pulses=3", disp_value, pulses);
      end
      game_over = 1'b0; score = 16'd0;
      tick();
   endtask

   task automatic test_record_blink();
      logic [7:0] pat = 8'd0;
      score = 16'd1500; hiscore = 16'd1500; game_over = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i >= 8 && i < 16) pat[15 - i] = disp_blank;
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {e_val, e_blank, e_src, e_slot}) begin
            failures++;
            $display("FAIL blink_cycle%0d got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i,
                     disp_value, disp_blank, disp_src, slot_start, e_val, e_blank, e_src, e_slot);
         end
      end
      checks++;
      if (pat !== 8'b0011_0011 || disp_blank !== 1'b0) begin
         failures++;
         $display("FAIL blink_pattern got %b end_blank=%0b want 00110011 end_blank=0", pat, disp_blank);
      end
      game_over = 1'b0;
      tick();
   endtask

   task automatic test_alert();
      int pulses = 0;
      score = 16'd321; game_over = 1'b0;
      for (int i = 0; i < 16; i++) begin
         alert_req = (i == 0 || i == 8);
         alert_value = (i == 0) ? 16'd7 : 16'd8;
         if (i == 3) begin alert_req = 1'b1; alert_value = 16'd8; end
         tick();
         if (slot_start) pulses++;
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {e_val, e_blank, e_src, e_slot}) begin
            failures++;
            $display("FAIL alert_cycle%0d got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i,
                     disp_value, disp_blank, disp_src, slot_start, e_val, e_blank, e_src, e_slot);
         end
      end
      alert_req = 1'b0;
      checks++;
      if (pulses != 4) begin
         failures++;
         $display("FAIL alert_pulses got %0d want 4", pulses);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 20; i++) begin
         alert_req = (i == 0 || i == 12);
         alert_value = 16'd4242;
         game_over = (i < 14);
         score = 16'(100 + i); hiscore = 16'd20000;
         tick();
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {e_val, e_blank, e_src, e_slot}) begin
            failures++;
            $display("FAIL simul_cycle%0d got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i,
                     disp_value, disp_blank, disp_src, slot_start, e_val, e_blank, e_src, e_slot);
         end
      end
      alert_req = 1'b0; game_over = 1'b0;
      tick();
   endtask

   task automatic test_mid_exit();
      bit found = 1'b0;
      score = 16'd10; hiscore = 16'd5; game_over = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_mode == 2 && m_elapsed == 3) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || disp_src !== 2'd1) begin
         failures++;
         $display("FAIL reach_gohi got src=%0d want 1", disp_src);
      end
      game_over = 1'b0;
      tick();
      checks++;
      if (disp_src !== 2'd0 || disp_blank !== 1'b0 || disp_value !== 16'd10 || slot_start !== 1'b1) begin
         failures++;
         $display("FAIL gohi_exit got %0d/%0b/%0d/%0b want 10/0/0/1",
                  disp_value, disp_blank, disp_src, slot_start);
      end
      alert_req = 1'b1; alert_value = 16'd77;
      tick();
      alert_req = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({disp_value, disp_blank, disp_src, slot_start} !== {16'd0, 1'b0, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_in_alert got %0d/%0b/%0d/%0b want 0/0/0/0",
                  disp_value, disp_blank, disp_src, slot_start);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         alert_req = ($urandom_range(0, 19) == 0);
         alert_value = 16'($urandom_range(0, 20000));
         if ($urandom_range(0, 29) == 0) game_over = ~game_over;
         if ($urandom_range(0, 3) == 0) score = 16'($urandom_range(0, 15000));
         if ($urandom_range(0, 7) == 0) hiscore = 16'($urandom_range(0, 15000));
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
         checks++;
         if ({disp_value, disp_blank, disp_src, slot_start} !== {e_val, e_blank, e_src, e_slot}) begin
            failures++;
            $display("FAIL random_cycle%0d got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i,
                     disp_value, disp_blank, disp_src, slot_start, e_val, e_blank, e_src, e_slot);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; score = 16'd0; hiscore = 16'd0; game_over = 1'b0;
      alert_req = 1'b0; alert_value = 16'd0;
      m_mode = 0; m_elapsed = 0; m_s = 0; m_h = 0; m_a = 0;
      @(negedge clk);
      test_reset();
      test_game_over_no_record();
      test_record_blink();
      test_alert();
      test_simultaneous();
      test_mid_exit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Decides which value the 4-digit seven-segment driver shows, and when: live score during play, alternating final score / high score after game over, and a timed pre-emptive alert value.
- Sits between game logic and the display driver; drives the driver's 16-bit binary number input plus a blank control.
- Holds each displayed value for a whole slot so digits never tear, and clamps every value to the 4-digit range.

Parameters:
DWELL_CYCLES, 100_000_000, cycles per game-over slot (score or high score)
ALERT_CYCLES, 200_000_000, cycles an alert is held
BLINK_CYCLES, 25_000_000, half-period of blanking during new-record display

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
score  input  16  live binary score
hiscore  input  16  binary high score
game_over  input  1  level, game ended
alert_req  input  1  single-cycle alert request
alert_value  input  16  value to show for alert, sampled with alert_req
disp_value  output  16  binary number to display driver, always 0..9999
disp_blank  output  1  1 = display driver blanks all digits
disp_src  output  2  0 = score, 1 = high score, 2 = alert, 3 unused
slot_start  output  1  one-cycle pulse on first cycle of each new slot

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- All outputs are registered. An input event sampled at edge k is visible on the outputs after edge k. Latency is 1 cycle.
- Reset (rst_n=0 at an edge):
  - state=PLAY; disp_value=0; disp_blank=0; disp_src=0; slot_start=0.
  - Dwell, alert and blink counters cleared; latched values cleared.
  - Reset mid-slot or mid-alert aborts immediately.
- Clamp: clamp(x) = (x > 9999) ? 9999 : x. It applies to every value driven on disp_value.
- State PLAY (src=0, blank=0):
  - disp_value = clamp(score), updated every cycle.
  - If alert_req, go to ALERT.
  - Else if game_over, go to GO_SCORE.
- State GO_SCORE (src=0, blank=0):
  - On entry, latch S=clamp(score) and H=clamp(hiscore); disp_value=S for the slot.
  - Dwell counter runs 0..DWELL_CYCLES-1; at terminal count go to GO_HI.
- State GO_HI (src=1):
  - disp_value=H, the value latched on GO_SCORE entry (the pair is latched once per GO_SCORE entry).
  - Same dwell count; at terminal count go to GO_SCORE, which re-latches S and H.
  - New record (S >= H): disp_blank toggles every BLINK_CYCLES, starting at 0 on slot entry.
  - Otherwise disp_blank=0.
  - Leaving GO_HI forces disp_blank=0.
- GO_SCORE / GO_HI exits:
  - game_over=0 goes to PLAY next edge, from any point in the slot. Counters clear.
  - alert_req goes to ALERT.
- State ALERT (src=2, blank=0):
  - On entry, latch A=clamp(alert_value); disp_value=A.
  - Alert counter runs 0..ALERT_CYCLES-1; at terminal count go to GO_SCORE if game_over=1, else PLAY.
  - alert_req during ALERT re-latches A, restarts the counter and pulses slot_start.
- Priority when events coincide in one cycle: reset > alert_req > game_over change > dwell/alert terminal count.
- slot_start pulses exactly one cycle on:
  - every state entry, including GO_SCORE <-> GO_HI alternation;
  - every alert retrigger.
- slot_start does not pulse on the first cycle after reset.
- Counters:
  - Each counter is $clog2(max param) bits wide.
  - Terminal-count compare is exact equality with param-1; there is no wrap-around past terminal.
  - Parameter value 1 gives a 1-cycle slot.
- Inputs are treated as synchronous to clk.

Test Plan:
- Params DWELL=8, ALERT=5, BLINK=2 for all tests.
- Reset and PLAY: hold rst_n=0 then release, score=1234 -> disp_value=0, src=0, blank=0 during reset; disp_value=1234 one cycle after release. Then score=12000 -> disp_value=9999.
- Game over, no record: score=50, hiscore=900, assert game_over -> slot_start pulse, then:
  - disp_value=50, src=0 for 8 cycles;
  - then 900, src=1 for 8 cycles, blank=0;
  - then 50 again with slot_start pulse.
  - Changing score to 60 mid-slot leaves 50 until the next GO_SCORE entry.
- New record blink: score=1500, hiscore=1500, game_over=1 -> in the GO_HI slot disp_value=1500, src=1, blank pattern 0,0,1,1,0,0,1,1 across its 8 cycles; blank=0 on return to GO_SCORE.
- Alert pre-emption and retrigger:
  - In PLAY, alert_req with alert_value=7 -> src=2, disp_value=7 for 5 cycles, then back to PLAY showing score.
  - Second alert_req (value 8) at alert cycle 3 -> disp_value=8, counter restarts, 5 more cycles, slot_start pulses at both requests.
- Simultaneous events:
  - alert_req and game_over rise in the same cycle -> ALERT first; after 5 cycles go to GO_SCORE (game_over still 1).
  - game_over drops during ALERT -> return to PLAY.
- Mid-operation exits:
  - game_over falls at GO_HI cycle 3 -> PLAY next cycle, src=0, blank=0.
  - rst_n=0 at ALERT cycle 2 -> all outputs at reset values on the next edge.
